// File: rtl/sync_pulse_event_collector_if.sv
// rtl/sync_pulse_event_collector_if.sv - event drain handshake between collector and consumer
interface sync_pulse_event_collector_if #(
  parameter int CNT_W = 4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending_cnt;

  modport master (
    output evt_valid,
    output pending_cnt,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  pending_cnt,
    output evt_ready
  );
endinterface

// File: rtl/sync_pulse_event_collector.sv
// rtl/sync_pulse_event_collector.sv - resync, edge-detect and queue slow-domain events (option: SPC_GLITCH_FILTER_EN)
module sync_pulse_event_collector #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TOT_W       = 16
) (
  input  logic                         i_clk_slow,
  input  logic                         i_rst,
  input  logic                         i_level_in,
  input  logic                         i_ovf_clr,
  output logic                         o_evt_pulse,
  output logic [TOT_W-1:0]             o_total_cnt,
  output logic                         o_overflow,
  sync_pulse_event_collector_if.master evt_if
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TOT_W-1:0] TOT_ONE = TOT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_evt_pulse;
  logic [CNT_W-1:0]       r_pending;
  logic [TOT_W-1:0]       r_total;
  logic                   r_overflow;

  logic w_sync_q;
  logic w_edge;
  logic w_accept;
  logic w_at_max;
  logic w_ovf_set;

  assign w_sync_q = r_sync[SYNC_STAGES-1];

`ifdef SPC_GLITCH_FILTER_EN
  // Extra history flop: demand two consecutive highs after a low.
  logic r_prev2;

  always_ff @(posedge i_clk_slow) begin
    if (i_rst) begin
      r_prev2 <= 1'b0;
    end else begin
      r_prev2 <= r_prev;
    end
  end

  assign w_edge = w_sync_q && r_prev && !r_prev2;
`else
  assign w_edge = w_sync_q && !r_prev;
`endif

  assign evt_if.evt_valid   = (r_pending != '0);
  assign evt_if.pending_cnt = r_pending;

  assign w_accept  = evt_if.evt_valid && evt_if.evt_ready;
  assign w_at_max  = &r_pending;
  assign w_ovf_set = r_evt_pulse && !w_accept && w_at_max;

  always_ff @(posedge i_clk_slow) begin
    if (i_rst) begin
      r_sync      <= '0;
      r_prev      <= 1'b0;
      r_evt_pulse <= 1'b0;
      r_pending   <= '0;
      r_total     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_level_in};
      r_prev      <= w_sync_q;
      r_evt_pulse <= w_edge;

      if (r_evt_pulse) begin
        r_total <= r_total + TOT_ONE;
      end

      // Simultaneous increment and accept cancel out, even at saturation.
      if (r_evt_pulse && !w_accept) begin
        if (!w_at_max) begin
          r_pending <= r_pending + CNT_ONE;
        end
      end else if (!r_evt_pulse && w_accept) begin
        r_pending <= r_pending - CNT_ONE;
      end

      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (i_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_evt_pulse = r_evt_pulse;
  assign o_total_cnt = r_total;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_sync_pulse_event_collector.sv
// tb/tb_sync_pulse_event_collector.sv - table-driven and scoreboard bench for sync_pulse_event_collector
module tb_sync_pulse_event_collector;

  localparam int CNT_W = 4;
  localparam int TOT_W = 4;
`ifdef SPC_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             level_in;
  logic             ovf_clr;
  logic             evt_pulse;
  logic [TOT_W-1:0] total_cnt;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_q[$];

  sync_pulse_event_collector_if #(.CNT_W(CNT_W)) u_if ();

  sync_pulse_event_collector #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .TOT_W      (TOT_W)
  ) u_dut (
    .i_clk_slow (clk),
    .i_rst      (rst),
    .i_level_in (level_in),
    .i_ovf_clr  (ovf_clr),
    .o_evt_pulse(evt_pulse),
    .o_total_cnt(total_cnt),
    .o_overflow (overflow),
    .evt_if     (u_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each observed pulse must match the oldest expected pulse cycle.
  always @(negedge clk) begin
    if (evt_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", cyc, -1);
      end else begin
        check("pulse_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    level_in = 1'b0;
    ovf_clr = 1'b0;
    u_if.evt_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_events(input int n);
    for (int i = 0; i < n; i++) begin
      level_in = 1'b1;
      exp_q.push_back(cyc + LAT);
      repeat (3) step();
      level_in = 1'b0;
      repeat (3) step();
    end
  endtask

  // One event whose pulse cycle coincides with the given ready/clear strobes.
  task automatic event_with_strobe(input logic rdy, input logic clr);
    int n0;
    n0 = cyc;
    level_in = 1'b1;
    exp_q.push_back(n0 + LAT);
    while (cyc < n0 + LAT) begin
      step();
      if (cyc >= n0 + 3) level_in = 1'b0;
    end
    u_if.evt_ready = rdy;
    ovf_clr = clr;
    step();
    u_if.evt_ready = 1'b0;
    ovf_clr = 1'b0;
    level_in = 1'b0;
    repeat (3) step();
  endtask

  typedef struct {
    int   n_evt;
    logic ready;
    int   exp_pending;
    logic exp_ovf;
    int   exp_total;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0;
    vecs[0] = '{0,  1'b0, 0,  1'b0, 0};
    vecs[1] = '{1,  1'b1, 0,  1'b0, 1};
    vecs[2] = '{4,  1'b0, 4,  1'b0, 4};
    vecs[3] = '{3,  1'b1, 0,  1'b0, 3};
    vecs[4] = '{15, 1'b0, 15, 1'b0, 15};
    vecs[5] = '{16, 1'b0, 15, 1'b1, 0};
    vecs[6] = '{18, 1'b0, 15, 1'b1, 2};

    // Idle after reset: everything stays zero.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {evt_pulse, u_if.evt_valid, overflow, u_if.pending_cnt, total_cnt}, 0);
      step();
    end

    for (int v = 0; v < 7; v++) begin
      do_reset();
      u_if.evt_ready = vecs[v].ready;
      send_events(vecs[v].n_evt);
      repeat (4) step();
      @(negedge clk);
      check($sformatf("vec%0d_pending", v), u_if.pending_cnt, vecs[v].exp_pending);
      check($sformatf("vec%0d_valid", v), u_if.evt_valid, (vecs[v].exp_pending != 0) ? 1 : 0);
      check($sformatf("vec%0d_overflow", v), overflow, vecs[v].exp_ovf);
      check($sformatf("vec%0d_total", v), total_cnt, vecs[v].exp_total);
    end

    // Single event, ready high: pending goes 0 -> 1 -> 0.
    do_reset();
    u_if.evt_ready = 1'b1;
    n0 = cyc;
    level_in = 1'b1;
    exp_q.push_back(n0 + LAT);
    while (cyc < n0 + LAT) step();
    @(negedge clk);
    check("single_pending_at_pulse", u_if.pending_cnt, 0);
    step();
    @(negedge clk);
    check("single_pending_after", u_if.pending_cnt, 1);
    step();
    @(negedge clk);
    check("single_pending_drained", u_if.pending_cnt, 0);
    repeat (4) step();
    level_in = 1'b0;
    repeat (4) step();
    check("single_total", total_cnt, 1);

    // Four queued events drain one per cycle.
    do_reset();
    send_events(4);
    u_if.evt_ready = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      @(negedge clk);
      check("drain_pending", u_if.pending_cnt, k);
      step();
    end
    check("drain_valid_low", u_if.evt_valid, 0);

    // Increment coincident with accept at pending=2.
    do_reset();
    send_events(2);
    event_with_strobe(1'b1, 1'b0);
    @(negedge clk);
    check("coincident_pending", u_if.pending_cnt, 2);
    check("coincident_overflow", overflow, 0);

    // Saturation, then clear, then a set racing a clear.
    do_reset();
    send_events(15);
    event_with_strobe(1'b1, 1'b0);
    @(negedge clk);
    check("max_lossless_pending", u_if.pending_cnt, 15);
    check("max_lossless_overflow", overflow, 0);
    send_events(1);
    @(negedge clk);
    check("sat_overflow", overflow, 1);
    check("sat_total", total_cnt, 1);
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_overflow", overflow, 0);
    check("clr_pending_kept", u_if.pending_cnt, 15);
    event_with_strobe(1'b0, 1'b1);
    @(negedge clk);
    check("set_beats_clr", overflow, 1);

    // Level already high when reset releases yields one event.
    rst = 1'b1;
    level_in = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.push_back(cyc + LAT);
    repeat (LAT + 3) step();
    @(negedge clk);
    check("high_at_release_total", total_cnt, 1);
    level_in = 1'b0;
    repeat (3) step();

    // Reset in the middle of a drain.
    do_reset();
    send_events(4);
    u_if.evt_ready = 1'b1;
    step();
    @(negedge clk);
    check("middrain_pending", u_if.pending_cnt, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    u_if.evt_ready = 1'b0;
    @(negedge clk);
    check("middrain_reset", {evt_pulse, u_if.evt_valid, overflow, u_if.pending_cnt, total_cnt}, 0);

`ifdef SPC_GLITCH_FILTER_EN
    // A single-cycle high is filtered out.
    do_reset();
    level_in = 1'b1;
    step();
    level_in = 1'b0;
    repeat (10) step();
    @(negedge clk);
    check("glitch_total", total_cnt, 0);
`endif

    repeat (4) step();
    check("missing_pulses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
